// File: rtl/ahb_bus_arbiter_if.sv
// Bus bundle between the masters/slave environment and the round-robin AHB-lite arbiter.
// Master-side signals are packed per master; routed signals go to the slave's decoder.
interface ahb_bus_arbiter_if #(
  parameter int unsigned NUM_M  = 2,
  parameter int unsigned ADDR_W = 31,
  parameter int unsigned DATA_W = 32
);
  logic [NUM_M-1:0]        HBUSREQ;
  logic [NUM_M-1:0]        M_HTRANS;
  logic [NUM_M-1:0]        M_HWRITE;
  logic [NUM_M-1:0]        M_HBURST;
  logic [NUM_M*ADDR_W-1:0] M_HADDR;
  logic [NUM_M*DATA_W-1:0] M_HWDATA;
  logic                    HREADY;

  logic [NUM_M-1:0]        HGRANT;
  logic [2:0]              HMASTER;
  logic                    HTRANS;
  logic                    HWRITE;
  logic                    HBURST;
  logic [ADDR_W-1:0]       HADDR;
  logic [DATA_W-1:0]       HWDATA;

  // Environment side: masters plus the slave's HREADY.
  modport master (
    output HBUSREQ, M_HTRANS, M_HWRITE, M_HBURST, M_HADDR, M_HWDATA, HREADY,
    input  HGRANT, HMASTER, HTRANS, HWRITE, HBURST, HADDR, HWDATA
  );

  // Arbiter side.
  modport slave (
    input  HBUSREQ, M_HTRANS, M_HWRITE, M_HBURST, M_HADDR, M_HWDATA, HREADY,
    output HGRANT, HMASTER, HTRANS, HWRITE, HBURST, HADDR, HWDATA
  );
endinterface

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB-lite arbiter with address mux, data-phase tracking and a bounded hold
// time that bursts may exceed.
module ahb_bus_arbiter #(
  parameter int unsigned NUM_M    = 2,
  parameter int unsigned ADDR_W   = 31,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_HOLD = 8
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_bus_arbiter_if.slave bus
);
  localparam int unsigned   CntW     = $clog2(MAX_HOLD + 1);
  localparam logic [CntW-1:0] HoldMax  = CntW'(MAX_HOLD);
  localparam logic [CntW-1:0] HoldLast = CntW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {StPark, StOwn, StSwitch} state_e;

  state_e          state_q, state_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      data_owner_q, data_owner_d;
  logic [2:0]      last_owner_q, last_owner_d;
  logic [CntW-1:0] beat_cnt_q, beat_cnt_d;

  // Per-master views padded to 8 entries so any 3-bit index is in range.
  logic [7:0]        req_pad, trans_pad, write_pad, burst_pad;
  logic [ADDR_W-1:0] addr_arr  [8];
  logic [DATA_W-1:0] wdata_arr [8];

  for (genvar i = 0; i < 8; i++) begin : g_pad
    if (i < NUM_M) begin : g_m
      assign req_pad[i]   = bus.HBUSREQ[i];
      assign trans_pad[i] = bus.M_HTRANS[i];
      assign write_pad[i] = bus.M_HWRITE[i];
      assign burst_pad[i] = bus.M_HBURST[i];
      assign addr_arr[i]  = bus.M_HADDR[i*ADDR_W +: ADDR_W];
      assign wdata_arr[i] = bus.M_HWDATA[i*DATA_W +: DATA_W];
    end else begin : g_z
      assign req_pad[i]   = 1'b0;
      assign trans_pad[i] = 1'b0;
      assign write_pad[i] = 1'b0;
      assign burst_pad[i] = 1'b0;
      assign addr_arr[i]  = '0;
      assign wdata_arr[i] = '0;
    end
  end

  logic [2:0] hmaster;
  logic [2:0] rr_base, winner, cand;
  logic       found, any_req, others_req, hold_hit;

  assign hmaster    = (state_q == StPark) ? 3'd0 : owner_q;
  assign any_req    = |req_pad;
  assign others_req = |(req_pad & ~(8'b1 << owner_q));
  assign hold_hit   = (beat_cnt_q >= HoldLast) && !burst_pad[owner_q] && others_req;

  // In SWITCH the outgoing owner becomes the round-robin base in the same cycle.
  always_comb begin
    rr_base = (state_q == StSwitch) ? owner_q : last_owner_q;
    winner  = rr_base;
    cand    = 3'd0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= NUM_M; k++) begin
      cand = 3'((32'(rr_base) + k) % NUM_M);
      if (!found && req_pad[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    data_owner_d = bus.HREADY ? hmaster : data_owner_q;
    if (bus.HREADY) begin
      unique case (state_q)
        StPark: begin
          if (any_req) begin
            owner_d = winner;
            state_d = StOwn;
          end
        end
        StOwn: begin
          if (trans_pad[owner_q] && (beat_cnt_q != HoldMax)) begin
            beat_cnt_d = beat_cnt_q + CntW'(1);
          end
          if (!req_pad[owner_q] || hold_hit) begin
            state_d = StSwitch;
          end
        end
        StSwitch: begin
          last_owner_d = owner_q;
          beat_cnt_d   = '0;
          if (any_req) begin
            owner_d = winner;
            state_d = StOwn;
          end else begin
            state_d = StPark;
          end
        end
        default: state_d = StPark;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q      <= StPark;
      owner_q      <= 3'd0;
      data_owner_q <= 3'd0;
      last_owner_q <= 3'(NUM_M - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      data_owner_q <= data_owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign bus.HGRANT  = (state_q == StOwn) ? NUM_M'(8'b1 << owner_q) : '0;
  assign bus.HMASTER = hmaster;
  assign bus.HTRANS  = (state_q == StOwn) && trans_pad[hmaster];
  assign bus.HWRITE  = write_pad[hmaster];
  assign bus.HBURST  = burst_pad[hmaster];
  assign bus.HADDR   = addr_arr[hmaster];
  assign bus.HWDATA  = wdata_arr[data_owner_q];
endmodule
